// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared types, channel count and one-hot helper for the 4-channel round-robin arbiter.
`default_nettype none

package rr_arb4_pkg;

  localparam int N_CH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Binary index of the set bit; an all-zero vector maps to 0.
  function automatic logic [1:0] oh_to_idx(input logic [N_CH-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb4_pick4.sv
// rr_pick4: combinational circular priority pick, first set request at or above ptr (mod 4).
`default_nettype none

module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [1:0]      ptr,
  output logic [N_CH-1:0] win_oh,
  output logic            any
);

  logic [1:0] cand;

  always_comb begin
    win_oh = '0;
    any    = 1'b0;
    cand   = 2'd0;
    for (int i = 0; i < N_CH; i++) begin
      cand = ptr + 2'(i);
      if (!any && req[cand]) begin
        win_oh[cand] = 1'b1;
        any          = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb4.sv
// rr_arb4: 4-channel round-robin arbiter with sticky registered one-hot grant, rev 1.0.
// Defining RR_ARB4_INDEX_OUT_EN adds the registered binary grant_idx output.
`default_nettype none

module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter logic [1:0] PTR_RESET = 2'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt_oh,
  output logic            gnt_valid,
  input  logic            gnt_ready,
  output logic            busy
`ifdef RR_ARB4_INDEX_OUT_EN
  ,
  output logic [1:0]      grant_idx
`endif
);

  state_e          state_q, state_d;
  logic [N_CH-1:0] gnt_oh_q, gnt_oh_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            accept;
  logic [1:0]      pick_ptr;
  logic [N_CH-1:0] win_oh;
  logic            win_any;

  // On accept the picker already sees the advanced pointer, giving back-to-back grants.
  rr_pick4 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .win_oh (win_oh),
    .any    (win_any)
  );

  always_comb begin
    accept   = (state_q == GRANT) && gnt_ready;
    pick_ptr = accept ? (oh_to_idx(gnt_oh_q) + 2'd1) : ptr_q;
    state_d  = state_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d  = GRANT;
          gnt_oh_d = win_oh;
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_d = pick_ptr;
          if (win_any) begin
            gnt_oh_d = win_oh;
          end else begin
            state_d  = IDLE;
            gnt_oh_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_oh_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_oh_q <= '0;
      ptr_q    <= PTR_RESET;
    end else begin
      state_q  <= state_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_oh    = gnt_oh_q;
  assign gnt_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);

`ifdef RR_ARB4_INDEX_OUT_EN
  logic [1:0] grant_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx_q <= 2'd0;
    end else begin
      grant_idx_q <= oh_to_idx(gnt_oh_d);
    end
  end

  assign grant_idx = grant_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: scoreboard bench driving two arbiters (PTR_RESET 0 and 2) against a queue-based model.
`default_nettype none

module tb_rr_arb4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       gnt_ready = 1'b0;

  logic [3:0] gnt_oh0, gnt_oh1;
  logic       gnt_valid0, gnt_valid1, busy0, busy1;
`ifdef RR_ARB4_INDEX_OUT_EN
  logic [1:0] gidx0, gidx1;
`endif

  rr_arb4 #(.PTR_RESET(2'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_oh(gnt_oh0),
    .gnt_valid(gnt_valid0), .gnt_ready(gnt_ready), .busy(busy0)
`ifdef RR_ARB4_INDEX_OUT_EN
    , .grant_idx(gidx0)
`endif
  );

  rr_arb4 #(.PTR_RESET(2'd2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_oh(gnt_oh1),
    .gnt_valid(gnt_valid1), .gnt_ready(gnt_ready), .busy(busy1)
`ifdef RR_ARB4_INDEX_OUT_EN
    , .grant_idx(gidx1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int ch0;   // expected granted channel, -1 for none
    int ch1;
  } exp_t;
  exp_t sb[$];

  // Reference model: a pending channel number and a pointer per instance.
  int pend[2];
  int ptr[2];
  int ptr_rst[2] = '{0, 2};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ch_oh(input int ch);
    logic [3:0] v;
    v = 4'b0000;
    if (ch >= 0) v[ch] = 1'b1;
    return v;
  endfunction

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_push();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = -1;
        ptr[k]  = ptr_rst[k];
      end else begin
        if (pend[k] >= 0 && gnt_ready) begin
          ptr[k]  = (pend[k] + 1) % 4;
          pend[k] = -1;
        end
        if (pend[k] < 0) begin
          for (int i = 0; i < 4; i++) begin
            if (pend[k] < 0 && req[(ptr[k] + i) % 4]) pend[k] = (ptr[k] + i) % 4;
          end
        end
      end
    end
    e.ch0 = pend[0];
    e.ch1 = pend[1];
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic g, input logic rn);
    @(negedge clk);
    rst_n     = rn;
    req       = r;
    gnt_ready = g;
    model_push();
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid0", int'(gnt_valid0), 0);
    chk("async_rst_oh0",    int'(gnt_oh0),    0);
    chk("async_rst_busy0",  int'(busy0),      0);
    chk("async_rst_oh1",    int'(gnt_oh1),    0);
    model_push();
  endtask

  // Monitor: compare every presented output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt_oh0",    int'(gnt_oh0),    int'(ch_oh(e.ch0)));
        chk("gnt_valid0", int'(gnt_valid0), int'(e.ch0 >= 0));
        chk("busy0",      int'(busy0),      int'(e.ch0 >= 0));
        chk("gnt_oh1",    int'(gnt_oh1),    int'(ch_oh(e.ch1)));
        chk("gnt_valid1", int'(gnt_valid1), int'(e.ch1 >= 0));
`ifdef RR_ARB4_INDEX_OUT_EN
        chk("grant_idx0", int'(gidx0), (e.ch0 >= 0) ? e.ch0 : 0);
        chk("grant_idx1", int'(gidx1), (e.ch1 >= 0) ? e.ch1 : 0);
`endif
      end
    end
  end

  initial begin
    pend = '{-1, -1};
    ptr  = '{0, 2};
    // Reset, then idle with no requests.
    repeat (2) step(4'b0000, 1'b0, 1'b0);
    repeat (5) step(4'b0000, 1'b0, 1'b1);
    // Single request on channel 2, accepted.
    step(4'b0100, 1'b1, 1'b1);
    repeat (2) step(4'b0000, 1'b1, 1'b1);
    // Wrap from pointer 3.
    repeat (2) step(4'b0101, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // Rotation with all requests held.
    repeat (7) step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // Stall with sticky grant while requests change.
    step(4'b0010, 1'b0, 1'b1);
    repeat (6) step(4'b1001, 1'b0, 1'b1);
    step(4'b1001, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // Ready while idle.
    repeat (2) step(4'b0000, 1'b1, 1'b1);
    // Randomized traffic.
    for (int n = 0; n < 300; n++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    // Asynchronous reset while a grant is pending.
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    async_reset_mid();
    step(4'b1111, 1'b0, 1'b0);
    repeat (4) step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The module SHALL have one parameter: PTR_RESET, default 2'd0, the priority pointer value loaded at reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port req, input, 4 bits, level-sensitive request lines, bit i = channel i.
REQ-005 The module SHALL have port gnt_oh, output, 4 bits, registered one-hot grant, consumed by the downstream 4-to-2 encoder.
REQ-006 The module SHALL have port gnt_valid, output, 1 bit, high when gnt_oh holds a valid grant.
REQ-007 The module SHALL have port gnt_ready, input, 1 bit, consumer accepts the grant when gnt_valid && gnt_ready.
REQ-008 The module SHALL have port busy, output, 1 bit, high when the FSM is in GRANT.

Function
REQ-009 The FSM SHALL have two states: IDLE and GRANT.
REQ-010 In IDLE with req == 0, the FSM SHALL stay in IDLE with gnt_oh = 0 and gnt_valid = 0.
REQ-011 In IDLE with req != 0, the winner SHALL be the first set bit scanning circularly from ptr upward (ptr, ptr+1, ... mod 4).
REQ-012 The winner SHALL appear on gnt_oh, with gnt_valid = 1, on the next rising edge (latency 1 cycle); the FSM then enters GRANT.
REQ-013 In GRANT, gnt_oh and gnt_valid SHALL stay stable until accepted, even if req changes or the winning request drops (sticky grant).
REQ-014 On accept (gnt_valid && gnt_ready), ptr SHALL load (winner index + 1) mod 4, with wrap 3 -> 0.
REQ-015 On accept, the module SHALL arbitrate the current req using the updated ptr in the same cycle: any request present gives a new grant next edge (stay in GRANT, back-to-back, no bubble); none gives gnt_oh = 0, gnt_valid = 0, and a return to IDLE.
REQ-016 gnt_oh SHALL have exactly one bit set when gnt_valid = 1, and all bits clear when gnt_valid = 0.
REQ-017 gnt_ready while gnt_valid = 0 SHALL have no effect.
REQ-018 ptr SHALL change only on accept.
REQ-019 busy SHALL equal (state == GRANT).

Reset
REQ-020 Asserting rst_n low SHALL immediately, without a clock edge, force state = IDLE, gnt_oh = 0, gnt_valid = 0, busy = 0, ptr = PTR_RESET, grant_idx = 0.
REQ-021 Reset mid-grant SHALL discard the pending grant with no accept recorded.
REQ-022 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-023 With macro RR_ARB4_INDEX_OUT_EN defined, the module SHALL add output grant_idx, 2 bits, the registered binary index of gnt_oh, updated on the same edge as gnt_oh.
REQ-024 With RR_ARB4_INDEX_OUT_EN undefined, the grant_idx port SHALL be absent, and encoding is left to the downstream encoder.

Structure
REQ-025 A shared package rr_arb4_pkg SHALL hold the state enum (IDLE, GRANT), the constant N_CH = 4, and the one-hot/index helper function.
REQ-026 The circular priority selection SHALL be one sub-module, rr_pick4: req and ptr in, one-hot winner plus any-flag out, purely combinational.

Verification
REQ-027 A bench SHALL check reset and idle: rst_n = 0, then 1; req = 4'b0000 for 5 cycles -> gnt_valid = 0, gnt_oh = 4'b0000, busy = 0.
REQ-028 A bench SHALL check a single request: ptr = 0, req = 4'b0100, gnt_ready = 1 -> gnt_oh = 4'b0100 one cycle later; after accept ptr = 3 (grant_idx = 2'd2 when enabled).
REQ-029 A bench SHALL check rotation: req held at 4'b1111, gnt_ready = 1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubble.
REQ-030 A bench SHALL check stall and sticky grant: req = 4'b0010, gnt_ready = 0 for 6 cycles while req drops to 4'b1001 -> gnt_oh stays 4'b0010; on gnt_ready = 1, next grant = 4'b1000 (ptr = 2).
REQ-031 A bench SHALL check wrap: ptr = 3 after granting channel 2, req = 4'b0101 -> grant 4'b0001 then 4'b0100.
REQ-032 A bench SHALL check asynchronous reset mid-grant: rst_n low between clock edges while gnt_valid = 1 -> outputs 0 immediately; after release with PTR_RESET = 2 and req = 4'b1111 -> first grant 4'b0100.
